// File: rtl/z8_bus_pkg.sv
// Shared definitions for the Z8 external memory bus arbiter.
package z8_bus_pkg;

   // Sequencer states: IDLE waits for a request, ACCESS drives the memory,
   // DONE returns the one-cycle acknowledge.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } arb_state_t;

   // Bus owner encoding, also used for last_owner.
   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DMA = 1'b1;

   // Width of the wait-state counter (WAIT_STATES is 0..7).
   localparam int CNT_W = 3;

endpackage

// File: rtl/z8_mem_arbiter_if.sv
// One requester port of the memory arbiter (CPU or DMA side).
//
// Handshake: req is a level. The requester raises req with we/addr/wdata and
// holds all four stable until it sees ack high for one cycle. On the clock
// edge that ends the ack cycle it either drops req or presents the next
// request; rdata is valid together with ack for reads and stays unchanged
// until the next read completion on this port.
interface z8_mem_arbiter_if #(
   parameter int ADDR_W = 16
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        wdata;
   logic              ack;
   logic [7:0]        rdata;

   // Requester side.
   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   // Arbiter side.
   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/z8_rr_select.sv
// Combinational winner selection between CPU and DMA requests.
module z8_rr_select
   import z8_bus_pkg::*;
#(
   parameter int CPU_PRIORITY = 0
) (
   input  logic cpu_req,
   input  logic dma_req,
   input  logic last_owner,
   output logic valid,
   output logic winner
);

   // A lone requester always wins; on a tie either the CPU wins outright or
   // the port that was not served last wins.
   always_comb begin
      valid  = cpu_req | dma_req;
      winner = OWNER_CPU;
      if (cpu_req && dma_req) begin
         winner = (CPU_PRIORITY != 0) ? OWNER_CPU : ~last_owner;
      end else if (dma_req) begin
         winner = OWNER_DMA;
      end
   end

endmodule

// File: rtl/z8_mem_arbiter.sv
// Two-port arbiter and sequencer for the Z8 external memory bus. Shares one
// single-access memory port between the CPU and a secondary DMA master.
module z8_mem_arbiter
   import z8_bus_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int WAIT_STATES  = 1,
   parameter int CPU_PRIORITY = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   z8_mem_arbiter_if.slave   cpu,
   z8_mem_arbiter_if.slave   dma,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              owner,
   output arb_state_t        dbg_state
);

   arb_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             last_owner;
   logic             win_valid;
   logic             winner;

   z8_rr_select #(
      .CPU_PRIORITY (CPU_PRIORITY)
   ) u_select (
      .cpu_req    (cpu.req),
      .dma_req    (dma.req),
      .last_owner (last_owner),
      .valid      (win_valid),
      .winner     (winner)
   );

   assign dbg_state = state;

   // Sequencer: latch the winning request, hold the memory for
   // WAIT_STATES+1 cycles, then pulse the winner's ack for one cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         last_owner <= OWNER_DMA;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         owner      <= OWNER_CPU;
         cpu.ack    <= 1'b0;
         cpu.rdata  <= '0;
         dma.ack    <= 1'b0;
         dma.rdata  <= '0;
      end else begin
         cpu.ack <= 1'b0;
         dma.ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (win_valid) begin
                  mem_en <= 1'b1;
                  busy   <= 1'b1;
                  owner  <= winner;
                  cnt    <= CNT_W'(WAIT_STATES);
                  state  <= ST_ACCESS;
                  if (winner == OWNER_DMA) begin
                     mem_we    <= dma.we;
                     mem_addr  <= dma.addr;
                     mem_wdata <= dma.wdata;
                  end else begin
                     mem_we    <= cpu.we;
                     mem_addr  <= cpu.addr;
                     mem_wdata <= cpu.wdata;
                  end
               end else begin
                  mem_en <= 1'b0;
               end
            end
            ST_ACCESS: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  // Last access cycle: read data is valid at this edge.
                  if (!mem_we) begin
                     if (owner == OWNER_DMA) dma.rdata <= mem_rdata;
                     else                    cpu.rdata <= mem_rdata;
                  end
                  if (owner == OWNER_DMA) dma.ack <= 1'b1;
                  else                    cpu.ack <= 1'b1;
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               last_owner <= owner;
               busy       <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_z8_mem_arbiter.sv
// Bench for z8_mem_arbiter: three instances (round-robin W=1, CPU priority
// W=1, round-robin W=0) driven by one directed sequence with a scoreboard.
module tb_z8_mem_arbiter;
   import z8_bus_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rst_n;
   logic        cpu_req [3];
   logic        cpu_we  [3];
   logic [15:0] cpu_addr [3];
   logic [7:0]  cpu_wdata [3];
   logic        dma_req [3];
   logic        dma_we  [3];
   logic [15:0] dma_addr [3];
   logic [7:0]  dma_wdata [3];

   wire [2:0]  cpu_ack, dma_ack, mem_en, mem_we, busy, owner;
   wire [7:0]  cpu_rdata [3];
   wire [7:0]  dma_rdata [3];
   wire [15:0] mem_addr [3];
   wire [7:0]  mem_wdata [3];
   wire [7:0]  mem_rd [3];
   wire [1:0]  st [3];

   int n_checks = 0;
   int n_fail   = 0;
   logic [10:0] exp_q[$];

   // Memory model: read data is a fixed function of the address
   // (0x0812 -> 0xA5, 0x0000 -> 0xBF, 0x0001 -> 0xBE).
   function automatic logic [7:0] mm(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hBF;
   endfunction

   function automatic logic [10:0] ent(input int d, input logic own, input logic [7:0] rd);
      logic [1:0] dd;
      dd = d[1:0];
      return {dd, own, rd};
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int WS = (g == 2) ? 0 : 1;
      localparam int PR = (g == 1) ? 1 : 0;
      z8_mem_arbiter_if #(.ADDR_W(16)) cpu_bus ();
      z8_mem_arbiter_if #(.ADDR_W(16)) dma_bus ();
      assign cpu_bus.req   = cpu_req[g];
      assign cpu_bus.we    = cpu_we[g];
      assign cpu_bus.addr  = cpu_addr[g];
      assign cpu_bus.wdata = cpu_wdata[g];
      assign cpu_ack[g]    = cpu_bus.ack;
      assign cpu_rdata[g]  = cpu_bus.rdata;
      assign dma_bus.req   = dma_req[g];
      assign dma_bus.we    = dma_we[g];
      assign dma_bus.addr  = dma_addr[g];
      assign dma_bus.wdata = dma_wdata[g];
      assign dma_ack[g]    = dma_bus.ack;
      assign dma_rdata[g]  = dma_bus.rdata;
      assign mem_rd[g]     = mm(mem_addr[g]);
      z8_mem_arbiter #(
         .ADDR_W       (16),
         .WAIT_STATES  (WS),
         .CPU_PRIORITY (PR)
      ) u_dut (
         .clk       (clk),
         .reset_n   (rst_n[g]),
         .cpu       (cpu_bus),
         .dma       (dma_bus),
         .mem_en    (mem_en[g]),
         .mem_we    (mem_we[g]),
         .mem_addr  (mem_addr[g]),
         .mem_wdata (mem_wdata[g]),
         .mem_rdata (mem_rd[g]),
         .busy      (busy[g]),
         .owner     (owner[g]),
         .dbg_state (st[g])
      );
   end

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) check1("ack_exclusive", cpu_ack[d] & dma_ack[d], 1'b0);
   endtask

   // Compare the acknowledged transfer against the scoreboard head.
   task automatic score(input int d);
      logic [10:0] obs;
      logic [10:0] exp;
      logic [1:0]  dd;
      dd  = d[1:0];
      obs = {dd, dma_ack[d], dma_ack[d] ? dma_rdata[d] : cpu_rdata[d]};
      check16("sb_pending", 16'(exp_q.size()), 16'd1);
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         check16("sb_ack", {5'd0, obs}, {5'd0, exp});
      end
   endtask

   task automatic wait_ack(input int d, input int budget);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < budget; c++) begin
         tick();
         if (cpu_ack[d] || dma_ack[d]) begin
            seen = 1'b1;
            break;
         end
      end
      check1("ack_seen", seen, 1'b1);
      if (seen) score(d);
   endtask

   task automatic check_zero(input int d);
      check1("rst_mem_en", mem_en[d], 1'b0);
      check1("rst_mem_we", mem_we[d], 1'b0);
      check16("rst_mem_addr", mem_addr[d], 16'h0000);
      check16("rst_mem_wdata", 16'(mem_wdata[d]), 16'h0000);
      check1("rst_busy", busy[d], 1'b0);
      check1("rst_owner", owner[d], 1'b0);
      check1("rst_cpu_ack", cpu_ack[d], 1'b0);
      check1("rst_dma_ack", dma_ack[d], 1'b0);
      check16("rst_cpu_rdata", 16'(cpu_rdata[d]), 16'h0000);
      check16("rst_dma_rdata", 16'(dma_rdata[d]), 16'h0000);
      check16("rst_state", 16'(st[d]), 16'(ST_IDLE));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 3'b000;
      for (int d = 0; d < 3; d++) begin
         cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = '0; cpu_wdata[d] = '0;
         dma_req[d] = 1'b0; dma_we[d] = 1'b0; dma_addr[d] = '0; dma_wdata[d] = '0;
      end

      // 1. Reset values, then idle after release.
      tick();
      tick();
      for (int d = 0; d < 3; d++) check_zero(d);
      rst_n = 3'b111;
      for (int i = 0; i < 3; i++) begin
         tick();
         check1("idle_busy", busy[0], 1'b0);
         check1("idle_mem_en", mem_en[0], 1'b0);
      end

      // 2. CPU read of 0x0812 on the W=1 round-robin instance.
      cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0812; cpu_req[0] = 1'b1;
      exp_q.push_back(ent(0, OWNER_CPU, 8'hA5));
      tick();
      check1("rd_mem_en_c1", mem_en[0], 1'b1);
      check16("rd_mem_addr", mem_addr[0], 16'h0812);
      check1("rd_mem_we", mem_we[0], 1'b0);
      check1("rd_busy", busy[0], 1'b1);
      check1("rd_owner", owner[0], OWNER_CPU);
      check16("rd_state", 16'(st[0]), 16'(ST_ACCESS));
      tick();
      check1("rd_mem_en_c2", mem_en[0], 1'b1);
      check1("rd_early_ack", cpu_ack[0], 1'b0);
      tick();
      check1("rd_mem_en_off", mem_en[0], 1'b0);
      check1("rd_cpu_ack", cpu_ack[0], 1'b1);
      check1("rd_dma_ack", dma_ack[0], 1'b0);
      check16("rd_done_state", 16'(st[0]), 16'(ST_DONE));
      score(0);
      cpu_req[0] = 1'b0;
      tick();
      check1("rd_ack_pulse", cpu_ack[0], 1'b0);
      check1("rd_busy_off", busy[0], 1'b0);
      check16("rd_rdata_hold", 16'(cpu_rdata[0]), 16'h00A5);

      // 3. DMA write of 0x3C to 0xF000.
      dma_we[0] = 1'b1; dma_addr[0] = 16'hF000; dma_wdata[0] = 8'h3C; dma_req[0] = 1'b1;
      exp_q.push_back(ent(0, OWNER_DMA, 8'h00));
      tick();
      check1("wr_mem_en", mem_en[0], 1'b1);
      check1("wr_mem_we", mem_we[0], 1'b1);
      check16("wr_mem_addr", mem_addr[0], 16'hF000);
      check16("wr_mem_wdata", 16'(mem_wdata[0]), 16'h003C);
      check1("wr_owner", owner[0], OWNER_DMA);
      tick();
      check1("wr_mem_we_c2", mem_we[0], 1'b1);
      tick();
      check1("wr_dma_ack", dma_ack[0], 1'b1);
      check1("wr_cpu_ack", cpu_ack[0], 1'b0);
      check1("wr_mem_en_off", mem_en[0], 1'b0);
      check1("wr_mem_we_off", mem_we[0], 1'b0);
      score(0);
      check16("wr_cpu_rdata", 16'(cpu_rdata[0]), 16'h00A5);
      dma_req[0] = 1'b0; dma_we[0] = 1'b0;
      tick();
      check1("wr_ack_pulse", dma_ack[0], 1'b0);
      check16("wr_cpu_rdata2", 16'(cpu_rdata[0]), 16'h00A5);

      // 4a. Both held high, round-robin: CPU, DMA, CPU, DMA.
      begin
         logic own;
         own = OWNER_CPU;
         cpu_we[0] = 1'b0; cpu_addr[0] = 16'h0100; cpu_req[0] = 1'b1;
         dma_we[0] = 1'b0; dma_addr[0] = 16'h0200; dma_req[0] = 1'b1;
         for (int i = 0; i < 4; i++) begin
            exp_q.push_back(ent(0, own, mm(own ? dma_addr[0] : cpu_addr[0])));
            wait_ack(0, 12);
            if (own == OWNER_CPU) begin
               cpu_addr[0] = cpu_addr[0] + 16'd1;
               if (i >= 2) cpu_req[0] = 1'b0;
            end else begin
               dma_addr[0] = dma_addr[0] + 16'd1;
               if (i >= 2) dma_req[0] = 1'b0;
            end
            own = ~own;
         end
         tick();
         tick();
         check1("rr_idle_busy", busy[0], 1'b0);
      end

      // 4b. Both held high, CPU priority: CPU x4 then the waiting DMA.
      cpu_we[1] = 1'b0; cpu_addr[1] = 16'h0300; cpu_req[1] = 1'b1;
      dma_we[1] = 1'b0; dma_addr[1] = 16'h0400; dma_req[1] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(ent(1, OWNER_CPU, mm(cpu_addr[1])));
         wait_ack(1, 12);
         cpu_addr[1] = cpu_addr[1] + 16'd1;
         if (i == 3) cpu_req[1] = 1'b0;
      end
      exp_q.push_back(ent(1, OWNER_DMA, mm(dma_addr[1])));
      wait_ack(1, 12);
      dma_req[1] = 1'b0;
      tick();

      // 5. Reset pulse during ACCESS of a CPU read; held request re-served.
      cpu_we[0] = 1'b0; cpu_addr[0] = 16'h1234; cpu_req[0] = 1'b1;
      exp_q.push_back(ent(0, OWNER_CPU, mm(16'h1234)));
      tick();
      check1("abort_mem_en_before", mem_en[0], 1'b1);
      #2 rst_n[0] = 1'b0;
      #1;
      check_zero(0);
      tick();
      check1("abort_no_ack", cpu_ack[0], 1'b0);
      #2 rst_n[0] = 1'b1;
      tick();
      check1("retry_mem_en", mem_en[0], 1'b1);
      check16("retry_mem_addr", mem_addr[0], 16'h1234);
      check1("retry_ack_c1", cpu_ack[0], 1'b0);
      tick();
      check1("retry_ack_c2", cpu_ack[0], 1'b0);
      tick();
      check1("retry_ack", cpu_ack[0], 1'b1);
      score(0);
      cpu_req[0] = 1'b0;
      tick();

      // 6. WAIT_STATES=0: back-to-back CPU reads of 0x0000 and 0x0001.
      cpu_we[2] = 1'b0; cpu_addr[2] = 16'h0000; cpu_req[2] = 1'b1;
      exp_q.push_back(ent(2, OWNER_CPU, mm(16'h0000)));
      tick();
      check1("w0_mem_en_a", mem_en[2], 1'b1);
      check16("w0_mem_addr_a", mem_addr[2], 16'h0000);
      tick();
      check1("w0_mem_en_a_off", mem_en[2], 1'b0);
      check1("w0_ack_a", cpu_ack[2], 1'b1);
      check16("w0_rdata_a", 16'(cpu_rdata[2]), 16'h00BF);
      score(2);
      cpu_addr[2] = 16'h0001;
      exp_q.push_back(ent(2, OWNER_CPU, mm(16'h0001)));
      tick();
      check1("w0_gap_ack", cpu_ack[2], 1'b0);
      check1("w0_gap_mem_en", mem_en[2], 1'b0);
      tick();
      check1("w0_mem_en_b", mem_en[2], 1'b1);
      check16("w0_mem_addr_b", mem_addr[2], 16'h0001);
      check16("w0_rdata_keep", 16'(cpu_rdata[2]), 16'h00BF);
      tick();
      check1("w0_ack_b", cpu_ack[2], 1'b1);
      check16("w0_rdata_b", 16'(cpu_rdata[2]), 16'h00BE);
      score(2);
      cpu_req[2] = 1'b0;
      tick();
      check1("w0_idle", busy[2], 1'b0);

      check16("sb_drained", 16'(exp_q.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/z8_mem_arbiter.md
Name: z8_mem_arbiter

Overview:
Two-port arbiter and sequencer for the Z8 SoC external memory bus (ROM/RAM data path). It shares one single-access memory port between the processor (port CPU) and a secondary bus master (port DMA, e.g. loader or video fetch). It registers the winning request, drives the memory for a parameterised number of wait states, and returns read data with a one-cycle acknowledge.

Parameters:
ADDR_W, 16, address width of requesters and memory port
WAIT_STATES, 1, extra memory cycles per access (0..7)
CPU_PRIORITY, 0, 1 = CPU always wins ties; 0 = round-robin between CPU and DMA

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, level
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  8  CPU write data
cpu_ack  out  1  one-cycle completion pulse to CPU
cpu_rdata  out  8  CPU read data, registered
dma_req, dma_we, dma_addr, dma_wdata, dma_ack, dma_rdata  same as the CPU port, for DMA
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  8  memory write data
mem_rdata  in  8  memory read data
busy  out  1  transaction in progress (state != IDLE)
owner  out  1  0 = CPU, 1 = DMA; valid while busy

Behaviour:
- Reset is asynchronous. All outputs go to 0 and state goes to IDLE. The wait counter is 0 and last_owner = DMA, so the CPU wins the first tie.
- Requester rules:
  - Hold req, we, addr and wdata stable until ack.
  - On the ack edge, either drop req or present the next request. Back-to-back requests are allowed.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is sampled high, select the winner.
  - Register addr, we and wdata into mem_*.
  - Set mem_en = 1, busy = 1 and owner = winner.
  - Load cnt = WAIT_STATES and go to ACCESS.
  - Otherwise mem_en = 0.
- ACCESS:
  - mem_* held. If cnt != 0, decrement.
  - If cnt == 0: for a read, capture mem_rdata into the winner's rdata register; then go to DONE.
  - mem_en is high for exactly WAIT_STATES+1 cycles.
- DONE:
  - mem_en = 0, mem_we = 0.
  - Pulse the winner's ack for one cycle and set last_owner = winner.
  - Go to IDLE next.
- Latency: req sampled at edge k gives mem_en high in cycles k+1 .. k+1+W and ack in cycle k+2+W, where W = WAIT_STATES. The minimum transaction period is W+3 cycles.
- Memory contract: mem_rdata must be valid at the clock edge ending the last ACCESS cycle.
- rdata changes only on a read completion for that port. Writes and the other port's accesses leave it unchanged.
- Arbitration with both requests high in IDLE:
  - CPU_PRIORITY=1: CPU wins.
  - Otherwise: the port != last_owner wins.
  - A single requester always wins.
- Requests arriving during ACCESS or DONE wait. They are not lost, since req is a level.
- Reset mid-transaction: the transaction is aborted immediately with no ack and mem_en deasserted asynchronously. A still-asserted req is re-served from IDLE after release.
- cpu_ack and dma_ack are never high together. At most one transaction is outstanding.

Decomposition:
- Shared package z8_bus_pkg holds:
  - the state encoding (ST_IDLE, ST_ACCESS, ST_DONE);
  - the owner constants (OWNER_CPU = 0, OWNER_DMA = 1);
  - the wait counter width (3).
- Optional sub-module z8_rr_select: combinational winner selection from the two req signals, last_owner and CPU_PRIORITY. Everything else stays in one module.

Test Plan:
1. Reset, WAIT_STATES=1:
   - Assert reset_n=0 mid-run -> all outputs 0 immediately.
   - Release with no req -> busy stays 0 and mem_en stays 0.
2. CPU read of 0x0812, memory returns 0xA5:
   - mem_addr=0x0812 and mem_en=1 for 2 cycles.
   - cpu_ack pulses in cycle k+3 with cpu_rdata=0xA5; dma_ack=0.
3. DMA write of 0x3C to 0xF000:
   - mem_we=1, mem_addr=0xF000 and mem_wdata=0x3C during ACCESS.
   - dma_ack pulses once; cpu_rdata keeps 0xA5.
4. Both requests held high for 4 transfers:
   - CPU_PRIORITY=0 -> owner sequence CPU, DMA, CPU, DMA, with acks alternating.
   - CPU_PRIORITY=1 -> CPU, CPU, CPU, CPU and no dma_ack.
5. reset_n pulsed low during ACCESS of a CPU read:
   - No cpu_ack and mem_en drops at once.
   - After release the held request completes normally, with ack W+2 cycles after the first IDLE edge.
6. WAIT_STATES=0, CPU back-to-back reads of 0x0000 and 0x0001:
   - mem_en high 1 cycle each.
   - Acks 3 cycles apart and rdata updated per ack.
